// File: rtl/sample_pipe_pkg.sv
// Shared types and constants for the sample-to-pipe writer.
// Optional build macro: TIMESTAMP_EN (adds a 16-bit sample index ahead of each sample).
package sample_pipe_pkg;

`ifdef TIMESTAMP_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_TS = 2'd1,
        WR_LO = 2'd2,
        WR_HI = 2'd3
    } wr_state_t;

    // Words pushed per accepted sample: index, low half, high half.
    localparam int unsigned WPS = 3;
    localparam wr_state_t   FIRST_WR_STATE = WR_TS;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } wr_state_t;

    // Words pushed per accepted sample: low half, high half.
    localparam int unsigned WPS = 2;
    localparam wr_state_t   FIRST_WR_STATE = WR_LO;
`endif

    // Word returned to the host when it reads an empty FIFO.
    localparam logic [15:0] UNDERRUN_WORD = 16'h0000;

endpackage

// File: rtl/sync_fifo16.sv
// 16-bit synchronous circular FIFO: one write port, one registered read port.
// Full/empty come from fill_count, so the pointers can wrap freely.
module sync_fifo16 #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          push,
    input  logic [15:0]   push_data,
    input  logic          pop,
    output logic [15:0]   pop_data,
    output logic [AW:0]   fill_count
);
    import sample_pipe_pkg::*;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [15:0]   mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (fill_count == '0);
    assign full    = (fill_count == DEPTH);
    // clear wins over both ports; a push into a full FIFO is only taken alongside a pop.
    assign do_pop  = pop & ~clear & ~empty;
    assign do_push = push & ~clear & (~full | do_pop);

    // Storage write port.
    // NOTE: the storage array is deliberately not reset so it maps onto block RAM; only pointers, count and the output register are reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_count <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   fill_count <= fill_count + (AW+1)'(1);
                2'b01:   fill_count <= fill_count - (AW+1)'(1);
                default: fill_count <= fill_count;
            endcase
        end
    end

    // Registered read port: old data on a same-address write, fill word on underrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pop_data <= '0;
        end else if (clear) begin
            pop_data <= '0;
        end else if (pop) begin
            pop_data <= empty ? UNDERRUN_WORD : mem[rd_ptr];
        end
    end

endmodule

// File: rtl/sample_to_pipe.sv
// Streaming writer: captures a 32-bit value per sample strobe, splits it into
// 16-bit words and buffers them for a block-throttled pipe-out endpoint.
// Optional build macro: TIMESTAMP_EN (prefixes each sample with a 16-bit index).
// BLOCK_WORDS must lie in 1 .. 2**AW.
module sample_to_pipe #(
    parameter int AW          = 10,
    parameter int BLOCK_WORDS = 256
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          sample_en,
    input  logic [31:0]   din,
    input  logic          pipe_read,
    output logic [15:0]   pipe_dout,
    output logic          pipe_ready,
    output logic [AW:0]   fill_count,
    output logic          overflow,
    output logic [15:0]   drop_count
);
    import sample_pipe_pkg::*;

    localparam logic [AW:0] DEPTH     = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] WPS_CNT   = (AW+1)'(WPS);
    localparam logic [AW:0] BLOCK_CNT = (AW+1)'(BLOCK_WORDS);

    wr_state_t     state;
    wr_state_t     state_next;
    logic [31:0]   hold;
    logic [AW:0]   free_space;
    logic          accept;
    logic          drop;
    logic          fifo_push;
    logic [15:0]   fifo_data;

`ifdef TIMESTAMP_EN
    logic [15:0]   sample_idx;
`endif

    // Space is judged on the count at the strobe cycle; the FSM is the only
    // writer, so space reserved here cannot be taken by anything else.
    assign free_space = DEPTH - fill_count;
    assign accept     = sample_en && (state == IDLE) && (free_space >= WPS_CNT);
    assign drop       = sample_en && !accept;

    // Next-state and push decode for the write FSM.
    // NOTE: every output of this block is given a default first, so no path leaves a value held and no latch is inferred.
    always_comb begin
        state_next = state;
        fifo_push  = 1'b0;
        fifo_data  = hold[15:0];
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = FIRST_WR_STATE;
                end
            end
`ifdef TIMESTAMP_EN
            WR_TS: begin
                fifo_push  = 1'b1;
                fifo_data  = sample_idx;
                state_next = WR_LO;
            end
`endif
            WR_LO: begin
                fifo_push  = 1'b1;
                fifo_data  = hold[15:0];
                state_next = WR_HI;
            end
            WR_HI: begin
                fifo_push  = 1'b1;
                fifo_data  = hold[31:16];
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM state register and sample holding register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            hold  <= '0;
        end else if (clear) begin
            state <= IDLE;
            hold  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                hold <= din;
            end
        end
    end

`ifdef TIMESTAMP_EN
    // Sample index: advances once per accepted sample, after its index word is pushed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sample_idx <= '0;
        end else if (clear) begin
            sample_idx <= '0;
        end else if (state == WR_TS) begin
            sample_idx <= sample_idx + 16'd1;
        end
    end
`endif

    // Drop accounting: sticky flag plus saturating counter of whole samples lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // Block-ready flag, one cycle behind the count it is derived from.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_ready <= 1'b0;
        end else if (clear) begin
            pipe_ready <= 1'b0;
        end else begin
            pipe_ready <= (fill_count >= BLOCK_CNT);
        end
    end

    sync_fifo16 #(
        .AW (AW)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .push       (fifo_push),
        .push_data  (fifo_data),
        .pop        (pipe_read),
        .pop_data   (pipe_dout),
        .fill_count (fill_count)
    );

endmodule

// File: tb/tb_sample_to_pipe.sv
// Scoreboard bench for sample_to_pipe: a large instance (AW=10, block 256)
// and a small one (AW=4, block 8). Stimulus pushes expected words into a
// queue per instance; a monitor per instance pops and compares on each read.
`timescale 1ns/1ps
module tb_sample_to_pipe;

`ifdef TIMESTAMP_EN
    localparam int          TB_WPS   = 3;
    localparam logic [3:0]  RD_SLOTS = 4'b0111;
`else
    localparam int          TB_WPS   = 2;
    localparam logic [3:0]  RD_SLOTS = 4'b0101;
`endif
    localparam int SM_DEPTH = 16;
    localparam int T2_N     = (256 + TB_WPS - 1) / TB_WPS;
    localparam int N_OK     = SM_DEPTH / TB_WPS;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0 drives the large instance, index 1 the small one.
    logic        rst_n [2];
    logic        clr   [2];
    logic        en    [2];
    logic [31:0] din   [2];
    logic        rd    [2];

    logic [15:0] b_dout,  s_dout;
    logic        b_ready, s_ready;
    logic [10:0] b_fill;
    logic [4:0]  s_fill;
    logic        b_ovf,   s_ovf;
    logic [15:0] b_drops, s_drops;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [15:0] idx [2];
    logic        rdp0 = 1'b0;
    logic        rdp1 = 1'b0;
    logic [15:0] e0, e1;
    int          wn;
    int          max_fill;
    int          nread;
    int          s;

    sample_to_pipe #(.AW(10), .BLOCK_WORDS(256)) u_big (
        .clk        (clk),
        .reset_n    (rst_n[0]),
        .clear      (clr[0]),
        .sample_en  (en[0]),
        .din        (din[0]),
        .pipe_read  (rd[0]),
        .pipe_dout  (b_dout),
        .pipe_ready (b_ready),
        .fill_count (b_fill),
        .overflow   (b_ovf),
        .drop_count (b_drops)
    );

    sample_to_pipe #(.AW(4), .BLOCK_WORDS(8)) u_small (
        .clk        (clk),
        .reset_n    (rst_n[1]),
        .clear      (clr[1]),
        .sample_en  (en[1]),
        .din        (din[1]),
        .pipe_read  (rd[1]),
        .pipe_dout  (s_dout),
        .pipe_ready (s_ready),
        .fill_count (s_fill),
        .overflow   (s_ovf),
        .drop_count (s_drops)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int get_fill(input int d);
        return (d == 0) ? int'(b_fill) : int'(s_fill);
    endfunction

    function automatic void push_exp(input int d, input logic [15:0] w);
        if (d == 0) q0.push_back(w);
        else        q1.push_back(w);
    endfunction

    function automatic void expect_sample(input int d, input logic [31:0] v);
`ifdef TIMESTAMP_EN
        push_exp(d, idx[d]);
        idx[d] = idx[d] + 16'd1;
`endif
        push_exp(d, v[15:0]);
        push_exp(d, v[31:16]);
    endfunction

    // One strobe, then idle long enough for the FSM to finish the sample.
    task automatic strobe(input int d, input logic [31:0] v, input bit model);
        en[d]  = 1'b1;
        din[d] = v;
        if (model) expect_sample(d, v);
        tick();
        en[d] = 1'b0;
        repeat (TB_WPS) tick();
    endtask

    task automatic read_n(input int d, input int n);
        rd[d] = 1'b1;
        repeat (n) tick();
        rd[d] = 1'b0;
    endtask

    task automatic wait_fill(input int d, input int target, input int budget, input string name);
        int i = 0;
        while (get_fill(d) != target && i < budget) begin
            tick();
            i++;
        end
        check(name, get_fill(d), target);
    endtask

    task automatic do_clear(input int d);
        clr[d] = 1'b1;
        tick();
        clr[d] = 1'b0;
        if (d == 0) q0.delete();
        else        q1.delete();
        idx[d] = '0;
    endtask

    // Monitor for the large instance: a read issued before this edge is checked after it.
    always @(negedge clk) begin
        if (rdp0) begin
            e0 = (q0.size() > 0) ? q0.pop_front() : 16'h0000;
            check("dout_big", b_dout, e0);
        end
        rdp0 = rd[0] && rst_n[0] && !clr[0];
    end

    // Monitor for the small instance.
    always @(negedge clk) begin
        if (rdp1) begin
            e1 = (q1.size() > 0) ? q1.pop_front() : 16'h0000;
            check("dout_small", s_dout, e1);
        end
        rdp1 = rd[1] && rst_n[1] && !clr[1];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            clr[d]   = 1'b0;
            en[d]    = 1'b0;
            din[d]   = '0;
            rd[d]    = 1'b0;
            idx[d]   = '0;
        end
        #23;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();

        // Reset state.
        check("rst_fill_big",  b_fill,  0);
        check("rst_dout_big",  b_dout,  0);
        check("rst_ready_big", b_ready, 0);
        check("rst_ovf_big",   b_ovf,   0);
        check("rst_drops_big", b_drops, 0);
        check("rst_fill_small", s_fill, 0);

        // 1: single sample, two-word readout, then an underrun read.
        strobe(0, 32'h3F80_0000, 1'b1);
        wait_fill(0, TB_WPS, 4, "t1_fill_full");
        check("t1_ready", b_ready, 0);
        read_n(0, TB_WPS);
        wait_fill(0, 0, 2, "t1_fill_empty");
        read_n(0, 1);
        tick();
        check("t1_underrun_fill", b_fill, 0);

        // 2: block threshold and in-order readout of i, 0 pairs.
        fork
            begin
                for (int i = 0; i < T2_N; i++) strobe(0, 32'(i), 1'b1);
            end
            begin
                wn = 0;
                while (b_fill < 11'd256 && wn < 2000) begin
                    @(negedge clk);
                    wn++;
                end
                check("t2_ready_lags", b_ready, 0);
                @(negedge clk);
                check("t2_ready_high", b_ready, 1);
            end
        join
        check("t2_fill", b_fill, T2_N * TB_WPS);
        read_n(0, T2_N * TB_WPS);
        tick();
        tick();
        check("t2_fill_drained", b_fill, 0);
        check("t2_ready_low", b_ready, 0);
        check("t2_no_drops", b_drops, 0);

        // 3: overflow on the small instance; the last accepted sample exactly fits.
        for (int i = 0; i < N_OK; i++) begin
            strobe(1, {16'hB000 + 16'(i), 16'hA000 + 16'(i)}, 1'b1);
        end
        check("t3_fill_full", s_fill, N_OK * TB_WPS);
        check("t3_no_ovf_yet", s_ovf, 0);
        strobe(1, 32'hDEAD_BEEF, 1'b0);
        check("t3_fill_kept", s_fill, N_OK * TB_WPS);
        check("t3_ovf", s_ovf, 1);
        check("t3_drops", s_drops, 1);
        check("t3_ready", s_ready, 1);
        read_n(1, N_OK * TB_WPS);
        wait_fill(1, 0, 3, "t3_drained");

        // 3b: a strobe while busy is dropped; the first sample is intact.
        en[1]  = 1'b1;
        din[1] = 32'h1234_5678;
        expect_sample(1, 32'h1234_5678);
        tick();
        din[1] = 32'h0BAD_0BAD;
        tick();
        en[1] = 1'b0;
        repeat (TB_WPS) tick();
        check("t3b_drops", s_drops, 2);
        check("t3b_fill", s_fill, TB_WPS);
        read_n(1, TB_WPS);
        tick();
        do_clear(1);
        check("clr_fill", s_fill, 0);
        check("clr_dout", s_dout, 0);
        check("clr_ovf", s_ovf, 0);
        check("clr_drops", s_drops, 0);

        // 4: balanced push/pop across many pointer wraps.
        max_fill = 0;
        nread    = 0;
        s        = 0;
        for (int c = 0; c < 600 && nread < 100 * TB_WPS; c++) begin
            en[1] = (c % 4 == 0) && (s < 100);
            if (en[1]) begin
                din[1] = {16'h5A00 + 16'(s), 16'(s)};
                expect_sample(1, din[1]);
                s++;
            end
            rd[1] = (c >= 12) && RD_SLOTS[c % 4] && (nread < 100 * TB_WPS);
            if (rd[1]) nread++;
            tick();
            if (int'(s_fill) > max_fill) max_fill = int'(s_fill);
        end
        en[1] = 1'b0;
        rd[1] = 1'b0;
        tick();
        tick();
        check("t4_fill_end", s_fill, 0);
        check("t4_drops", s_drops, 0);
        check("t4_ovf", s_ovf, 0);
        check("t4_fill_bound", 32'(max_fill <= 3 * TB_WPS), 1);
        check("t4_queue_empty", q1.size(), 0);

        // 5: asynchronous reset in the middle of a sample.
        en[1]  = 1'b1;
        din[1] = 32'h7777_8888;
        tick();
        din[1] = 32'h1111_2222;
        tick();
        en[1] = 1'b0;
`ifdef TIMESTAMP_EN
        tick();
`endif
        check("t5_busy_drop", s_drops, 1);
        #3;
        rst_n[1] = 1'b0;
        q1.delete();
        idx[1] = '0;
        #1;
        check("t5_rst_fill", s_fill, 0);
        check("t5_rst_dout", s_dout, 0);
        check("t5_rst_ready", s_ready, 0);
        check("t5_rst_ovf", s_ovf, 0);
        check("t5_rst_drops", s_drops, 0);
        #2;
        rst_n[1] = 1'b1;
        tick();
        read_n(1, 1);
        tick();
        check("t5_underrun_fill", s_fill, 0);
        strobe(1, 32'hCAFE_F00D, 1'b1);
        wait_fill(1, TB_WPS, 3, "t5_after_rst_fill");
        read_n(1, TB_WPS);
        wait_fill(1, 0, 3, "t5_after_rst_drained");

`ifdef TIMESTAMP_EN
        // 6: index words ahead of each sample, restarting after clear.
        do_clear(0);
        for (int i = 0; i < 3; i++) begin
            push_exp(0, 16'(i));
            push_exp(0, 16'h5555);
            push_exp(0, 16'hAAAA);
            strobe(0, 32'hAAAA_5555, 1'b0);
        end
        read_n(0, 9);
        wait_fill(0, 0, 3, "t6_drained");
        do_clear(0);
        push_exp(0, 16'h0000);
        push_exp(0, 16'h5555);
        push_exp(0, 16'hAAAA);
        strobe(0, 32'hAAAA_5555, 1'b0);
        read_n(0, 3);
        wait_fill(0, 0, 3, "t6_restart_drained");
`endif

        tick();
        tick();
        check("end_q_big", q0.size(), 0);
        check("end_q_small", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_to_pipe.md
Name: sample_to_pipe

Overview:
Streaming writer that feeds a block-throttled pipe-out endpoint. It captures a 32-bit simulation value, such as muscle length, f_total_force or a spike count, once per sample strobe. Each sample is split into 16-bit words and buffered in a circular FIFO. The host drains the FIFO in fixed-size blocks. It is the outbound counterpart of the pipe-to-waveform feeder and lives in the top level, clocked by ti_clk.

Parameters:
AW, 10, FIFO address width; depth = 2^AW 16-bit words.
BLOCK_WORDS, 256, words that must be buffered before pipe_ready asserts; must be ≤ 2^AW and ≥ 1.

Ports:
clk  in  1  ti_clk; all logic is on this edge.
reset_n  in  1  asynchronous, active-low reset.
clear  in  1  synchronous flush: empties the FIFO and zeroes the counters; driven from the reset_sim wire.
sample_en  in  1  single-cycle strobe (edge of sim_clk, detected upstream); captures din.
din  in  32  sample value (IEEE float or integer; treated as opaque).
pipe_read  in  1  pipe-out read strobe; one word is consumed per asserted cycle.
pipe_dout  out  16  word presented to the pipe-out datain.
pipe_ready  out  1  block available (count ≥ BLOCK_WORDS).
fill_count  out  AW+1  words currently stored.
overflow  out  1  sticky; a sample was dropped.
drop_count  out  16  number of dropped samples, saturating at 16'hFFFF.

Behaviour:
- Reset (reset_n=0, asynchronous), or clear=1 on a clock edge: pointers=0, fill_count=0, pipe_dout=0, pipe_ready=0, overflow=0, drop_count=0, FSM=IDLE, sample counter=0. clear has priority over every other input in that cycle.
- Write FSM, states IDLE, WR_LO, WR_HI:
  - IDLE → WR_LO on sample_en when free space ≥ WPS (words per sample; 2, or 3 with the optional feature). din is latched into a holding register in that cycle.
  - If free space < WPS, the whole sample is dropped, never a partial one: overflow←1, drop_count+1 (saturating), stay in IDLE.
  - WR_LO pushes hold[15:0]; WR_HI pushes hold[31:16] and returns to IDLE. A sample therefore occupies one push per cycle, and the low word always precedes the high word.
  - A sample_en arriving while the FSM is not in IDLE is counted as a drop. This is legal only if strobes come closer than WPS+1 cycles apart.
- Space check uses fill_count at the strobe cycle. Reserved space cannot be stolen, because only the FSM pushes.
- Read side:
  - On pipe_read with fill_count>0, pipe_dout is registered with mem[rd_ptr] at the next edge and rd_ptr increments. Read latency is 1 cycle: the word for the read in cycle k is valid from cycle k+1.
  - pipe_read while empty (underrun): pipe_dout←16'h0000, no pointer change, no flag.
- A push and a pop in the same cycle: fill_count unchanged, both pointers advance.
- Pointers are AW bits and wrap naturally modulo 2^AW. Full/empty are derived from fill_count (0 or 2^AW), never from pointer equality.
- pipe_ready is registered and equals (fill_count ≥ BLOCK_WORDS) after the update of that cycle. It lags by 1 cycle, which is safe because the host only starts a block after seeing ready.
- Memory is inferred as one-write/one-read block RAM; reading and writing the same address in the same cycle returns the old data. That case cannot occur for a non-empty read.

Optional Feature:
TIMESTAMP_EN.
- Defined: WPS=3. A 16-bit sample index (incremented per accepted sample, wraps FFFF→0000, not incremented on drops) is pushed in state WR_TS before WR_LO. Order: index, lo, hi. A host can detect drops from gaps in the index.
- Undefined: WPS=2, state WR_TS and the index counter are absent, and the output stream is pure lo/hi pairs.

Decomposition:
- Package sample_pipe_pkg: the FSM state enum, the WPS constant (selected by TIMESTAMP_EN) and the underrun fill word 16'h0000.
- One sub-module: sync_fifo16 (memory, pointers, fill_count, registered read port, push/pop interface).
- The FSM, drop logic and ready logic stay in sample_to_pipe.

Test Plan:
1. Reset then a single sample: din=32'h3F80_0000, one strobe, then two pipe_reads → pipe_dout 16'h0000 then 16'h3F80. fill_count goes 0→2→0; pipe_ready stays 0 with BLOCK_WORDS=256.
2. Block threshold: 128 samples with din=i → pipe_ready=1 one cycle after fill_count reaches 256. After 256 reads, words alternate i, 0 in order and pipe_ready=0.
3. Overflow: AW=4, no reads, 9 strobes → fill_count=16, overflow=1, drop_count=1. The data read back is samples 0..7 with no partial 9th sample.
4. Simultaneous push/pop across wrap (AW=4): continuous strobes every 4 cycles plus reads every 2 cycles for 100 samples → no drop, fill_count bounded, exact sequence preserved across the pointer wrap.
5. Asynchronous reset mid-WR_HI, and underrun: reset_n pulse → all outputs 0 immediately. A pipe_read while empty → pipe_dout=0 and fill_count stays 0.
6. TIMESTAMP_EN: 3 samples, 32'hAAAA_5555 each → words 0000,5555,AAAA,0001,5555,AAAA,0002,5555,AAAA. Then a clear → index restarts at 0000.
